my_dmux_stream: RTL and testbench
=================================

Name: my_dmux_stream

Overview:
Registered, parametrised N-way demultiplexer for WIDTH-bit data words with valid/ready handshaking on the input and on every output channel. It is the sequential successor to the 4-way single-bit dmux: it routes each accepted input word to the output channel chosen by sel. Each channel has a one-entry holding register, so a stalled consumer blocks only traffic addressed to that channel. It sits between a single producer and N independent consumers.

Parameters:
WIDTH, 8, data word width in bits (>=1)
N, 4, number of output channels (>=2, need not be a power of two)
SEL_W, $clog2(N), select width; derived, not overridden

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer has a word
in_ready  out  1  block accepts word this cycle
in_data  in  WIDTH  input word
sel  in  SEL_W  destination channel, sampled with in_data
out_valid  out  N  bit k: channel k holds a word
out_ready  in  N  bit k: consumer k takes word this cycle
out_data  out  N*WIDTH  channel k word at bits [k*WIDTH +: WIDTH]
sel_err  out  1  one-cycle pulse: word with sel >= N was dropped

Behaviour:
- Reset: all out_valid=0, out_data=0, sel_err=0. Reset in the middle of operation discards every held word in the next cycle. in_ready is 0 while reset is high.
- Slot k is free when out_valid[k]==0 or out_ready[k]==1 (same-cycle drain).
- in_ready is combinational: sel>=N gives 1; otherwise it is the free state of slot[sel]. There is no combinational path from in_data to outputs.
- Accept = in_valid & in_ready. On accept with sel<N, slot[sel] loads in_data and out_valid[sel]=1 on the next edge. Latency is 1 cycle from accept to out_valid.
- On accept with sel>=N, the word is dropped and sel_err=1 for exactly the next cycle. This can only occur for non-power-of-two N.
- Drain: out_valid[k]&out_ready[k] with no load to k gives out_valid[k]=0 next cycle. Drain and load on the same k in the same cycle gives out_valid[k] staying 1 with the new data, for full throughput of 1 word/cycle per channel.
- Held out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- out_data[k] keeps its last value after draining. Only reset clears it.
- Channels are independent. Back-pressure on k never blocks words addressed to j!=k.
- in_data and sel may change freely when in_valid=0.

Optional Feature:
Macro MY_DMUX_BROADCAST_EN.
- Defined: adds input port bcast (1 bit). An accept with bcast=1 ignores sel and loads in_data into all N slots. In this mode in_ready is the AND of every slot's free state, and sel_err is never raised.
- Undefined: there is no bcast port and behaviour is exactly as above.

Decomposition:
- Package my_dmux_pkg holds:
  - a clog2 helper function
  - a typedef for the slot state struct {logic valid; logic [WIDTH-1:0] data} (parametrised via the module)
  - the reset data constant (all zeros)
- One sub-module, my_dmux_slot: a one-entry register slice with load, data_in, ready, valid, and data_out. It is instantiated N times in a generate loop. The top-level handles decoding, in_ready, and sel_err.

Test Plan:
1. Reset, then N=4, WIDTH=8, all out_ready=1. Send 0xA5 to sel=2 -> next cycle out_valid=4'b0100, out_data[2]=0xA5; one cycle later out_valid=0.
2. out_ready[1]=0. Send 0x11 to sel=1, then 0x22 to sel=1 -> in_ready=0 on the second word and out_data[1] held at 0x11. Raise out_ready[1] -> 0x22 is accepted that same cycle and appears next cycle. Send 0x33 to sel=3 while channel 1 is stalled -> accepted, out_valid[3]=1.
3. Continuous stream to sel=0 with out_ready[0]=1, values 0..15 -> one word accepted per cycle with no bubbles; out_data[0] sequence is 0..15 with 1-cycle lag.
4. N=3: send 0x7E with sel=3 -> in_ready=1, no out_valid change, sel_err=1 for one cycle, then 0.
5. Hold words in all 4 slots with out_ready=0, then assert reset for 1 cycle -> out_valid=0, all out_data=0, sel_err=0.
6. With MY_DMUX_BROADCAST_EN: bcast=1, data 0x5A, all slots empty -> all out_valid=1 and all out_data=0x5A. Repeat with slot 2 stalled -> in_ready=0 until out_ready[2]=1.

Source files
------------

// File: rtl/my_dmux_pkg.sv
// Shared helpers for the my_dmux_stream demultiplexer.
// Build option: MY_DMUX_BROADCAST_EN (see my_dmux_stream).
package my_dmux_pkg;

    // Elaboration-time ceiling log2; value 1 yields 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Fill bit for slot data on reset; replicated to the module's WIDTH.
    localparam logic RESET_FILL = 1'b0;

endpackage

// File: rtl/my_dmux_slot.sv
// One-entry register slice for one demux output channel.
// Free means the slot can take a load this cycle, including when it drains in the same cycle.
module my_dmux_slot
    import my_dmux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data_out,
    output logic             free
);

    // The struct carries the module's WIDTH, so it is declared here rather than in the package.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } slot_state_t;

    slot_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state.valid <= 1'b0;
            state.data  <= {WIDTH{RESET_FILL}};
        end else if (load) begin
            state.valid <= 1'b1;
            state.data  <= data_in;
        end else if (state.valid && ready) begin
            state.valid <= 1'b0;
        end
    end

    assign valid    = state.valid;
    assign data_out = state.data;
    assign free     = ~state.valid | ready;

endmodule

// File: rtl/my_dmux_stream.sv
// Registered N-way valid/ready demultiplexer with one holding slot per channel.
// Build option: define MY_DMUX_BROADCAST_EN to add the bcast input (load all slots at once).
module my_dmux_stream
    import my_dmux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
`ifdef MY_DMUX_BROADCAST_EN
    input  logic               bcast,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               sel_err
);

    logic [N-1:0] sel_hit;
    logic [N-1:0] slot_free;
    logic [N-1:0] load;
    logic         sel_oor;
    logic         bcast_act;
    logic         accept;

`ifdef MY_DMUX_BROADCAST_EN
    assign bcast_act = bcast;
`else
    assign bcast_act = 1'b0;
`endif

    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < N; k++) begin
            sel_hit[k] = (sel == SEL_W'(k));
        end
    end

    // No channel matches only for non-power-of-two N; such words are accepted and dropped.
    assign sel_oor = ~|sel_hit;

    assign in_ready = ~reset & (bcast_act ? (&slot_free)
                                          : (sel_oor | (|(sel_hit & slot_free))));
    assign accept   = in_valid & in_ready;
    assign load     = {N{accept}} & (bcast_act ? {N{1'b1}} : sel_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= accept & sel_oor & ~bcast_act;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        my_dmux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .load    (load[k]),
            .data_in (in_data),
            .ready   (out_ready[k]),
            .valid   (out_valid[k]),
            .data_out(out_data[k*WIDTH +: WIDTH]),
            .free    (slot_free[k])
        );
    end

endmodule

// File: tb/tb_my_dmux_stream.sv
// Scoreboard bench for my_dmux_stream: a 4-channel instance with per-channel expected queues
// and a 3-channel instance for the out-of-range select path.
module tb_my_dmux_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [1:0]  sel = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '1;
    logic [31:0] out_data;
    logic        sel_err;

    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [7:0]  in_data3 = '0;
    logic [1:0]  sel3 = '0;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3 = '1;
    logic [23:0] out_data3;
    logic        sel_err3;

`ifdef MY_DMUX_BROADCAST_EN
    logic        bcast = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    always #5 clk = ~clk;

    my_dmux_stream #(.WIDTH(8), .N(4)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef MY_DMUX_BROADCAST_EN
        .bcast    (bcast),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sel_err  (sel_err)
    );

    my_dmux_stream #(.WIDTH(8), .N(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
`ifdef MY_DMUX_BROADCAST_EN
        .bcast    (1'b0),
`endif
        .in_valid (in_valid3),
        .in_ready (in_ready3),
        .in_data  (in_data3),
        .sel      (sel3),
        .out_valid(out_valid3),
        .out_ready(out_ready3),
        .out_data (out_data3),
        .sel_err  (sel_err3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int ch, input logic [7:0] d);
        case (ch)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word to the 4-channel DUT; expected output is queued when the handshake is seen.
    task automatic send(input logic [1:0] s, input logic [7:0] d);
        bit accepted;
        int n;
        accepted = 1'b0;
        n = 0;
        in_valid = 1'b1;
        sel      = s;
        in_data  = d;
        while (!accepted && n < 50) begin
            @(negedge clk);
            accepted = in_ready;
            if (accepted) push_exp(int'(s), d);
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word 0x%0h to sel %0d not accepted in 50 cycles", d, s);
        end
    endtask

    // Monitor: every word leaving the 4-channel DUT must match the head of its channel queue.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    logic [7:0] got;
                    logic [7:0] exp;
                    bit         have;
                    got  = out_data[k*8 +: 8];
                    have = 1'b1;
                    exp  = '0;
                    case (k)
                        0: if (q0.size() > 0) exp = q0.pop_front(); else have = 1'b0;
                        1: if (q1.size() > 0) exp = q1.pop_front(); else have = 1'b0;
                        2: if (q2.size() > 0) exp = q2.pop_front(); else have = 1'b0;
                        default: if (q3.size() > 0) exp = q3.pop_front(); else have = 1'b0;
                    endcase
                    checks++;
                    if (!have) begin
                        errors++;
                        $display("FAIL sb_unexpected ch%0d: got 0x%0h, want no word", k, got);
                    end else if (got !== exp) begin
                        errors++;
                        $display("FAIL sb_data ch%0d: got 0x%0h, want 0x%0h", k, got, exp);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with requests pending on both DUTs
        in_valid  = 1'b1;
        sel       = 2'd0;
        in_valid3 = 1'b1;
        sel3      = 2'd3;
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_in_ready3", in_ready3, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sel_err", sel_err, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        tick();

        // 1: single word to channel 2, all consumers ready
        out_ready = 4'hF;
        send(2'd2, 8'hA5);
        check("t1_valid", out_valid, 4'b0100);
        check("t1_data2", out_data[23:16], 8'hA5);
        tick();
        check("t1_drained", out_valid, 4'b0000);

        // 2: stall channel 1, second word must wait, other channel unaffected
        out_ready = 4'b1101;
        send(2'd1, 8'h11);
        check("t2_valid1", out_valid, 4'b0010);
        in_valid = 1'b1;
        sel      = 2'd1;
        in_data  = 8'h22;
        @(negedge clk);
        check("t2_blocked", in_ready, 0);
        tick();
        check("t2_held", out_data[15:8], 8'h11);
        out_ready = 4'hF;
        @(negedge clk);
        check("t2_release", in_ready, 1);
        if (in_ready) push_exp(1, 8'h22);
        tick();
        in_valid = 1'b0;
        check("t2_new_data", out_data[15:8], 8'h22);
        check("t2_new_valid", out_valid, 4'b0010);
        out_ready = 4'b1101;
        send(2'd3, 8'h33);
        check("t2_indep", out_valid, 4'b1010);
        check("t2_held2", out_data[15:8], 8'h22);
        out_ready = 4'hF;
        tick();
        tick();
        check("t2_empty", out_valid, 4'b0000);

        // 3: back-to-back stream to channel 0, one word per cycle
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            sel      = 2'd0;
            in_data  = 8'(i);
            @(negedge clk);
            check("t3_ready", in_ready, 1);
            if (in_ready) push_exp(0, 8'(i));
            tick();
            check("t3_data", out_data[7:0], 64'(i));
            check("t3_valid", out_valid[0], 1);
        end
        in_valid = 1'b0;
        tick();
        check("t3_empty", out_valid, 4'b0000);

        // 4: N=3, out-of-range select is accepted and dropped
        out_ready3 = 3'b000;
        in_valid3  = 1'b1;
        sel3       = 2'd3;
        in_data3   = 8'h7E;
        @(negedge clk);
        check("t4_ready_oor", in_ready3, 1);
        tick();
        in_valid3 = 1'b0;
        check("t4_sel_err", sel_err3, 1);
        check("t4_no_valid", out_valid3, 3'b000);
        tick();
        check("t4_sel_err_clr", sel_err3, 0);
        in_valid3 = 1'b1;
        sel3      = 2'd2;
        in_data3  = 8'h19;
        @(negedge clk);
        check("t4_ready_top", in_ready3, 1);
        tick();
        in_valid3 = 1'b0;
        check("t4_valid_top", out_valid3, 3'b100);
        check("t4_data_top", out_data3[23:16], 8'h19);
        check("t4_no_err", sel_err3, 0);

        // 5: fill every slot, then a one-cycle reset discards everything
        out_ready = 4'h0;
        send(2'd0, 8'hC0);
        send(2'd1, 8'hC1);
        send(2'd2, 8'hC2);
        send(2'd3, 8'hC3);
        check("t5_full", out_valid, 4'hF);
        check("t5_full_data", out_data, 32'hC3C2C1C0);
        reset     = 1'b1;
        in_valid3 = 1'b1;
        sel3      = 2'd3;
        @(negedge clk);
        check("t5_rst_ready3", in_ready3, 0);
        tick();
        reset     = 1'b0;
        in_valid3 = 1'b0;
        check("t5_valid", out_valid, 4'h0);
        check("t5_data", out_data, 32'h0);
        check("t5_sel_err", sel_err, 0);
        check("t5_valid3", out_valid3, 3'b000);
        check("t5_data3", out_data3, 24'h0);
        check("t5_sel_err3", sel_err3, 0);
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
        out_ready = 4'hF;
        tick();

`ifdef MY_DMUX_BROADCAST_EN
        // 6: broadcast to all slots, then with slot 2 stalled
        bcast    = 1'b1;
        in_valid = 1'b1;
        sel      = 2'd0;
        in_data  = 8'h5A;
        @(negedge clk);
        check("t6_ready", in_ready, 1);
        if (in_ready) for (int k = 0; k < 4; k++) push_exp(k, 8'h5A);
        tick();
        in_valid = 1'b0;
        bcast    = 1'b0;
        check("t6_valid", out_valid, 4'hF);
        check("t6_data", out_data, 32'h5A5A5A5A);
        check("t6_sel_err", sel_err, 0);
        tick();
        out_ready = 4'b1011;
        send(2'd2, 8'h44);
        bcast    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h6B;
        @(negedge clk);
        check("t6_blocked", in_ready, 0);
        tick();
        out_ready = 4'hF;
        @(negedge clk);
        check("t6_release", in_ready, 1);
        if (in_ready) for (int k = 0; k < 4; k++) push_exp(k, 8'h6B);
        tick();
        in_valid = 1'b0;
        bcast    = 1'b0;
        check("t6_valid2", out_valid, 4'hF);
        check("t6_data2", out_data, 32'h6B6B6B6B);
        tick();
        tick();
`endif

        check("sb_leftover", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
